sdram_port_arbiter: RTL

Two-requester arbiter and Avalon-MM master that shares the NIOS system's external SDRAM master port (avalon_mm_1) between the OV7670 capture writer and the VGA scan-out reader. It owns the port's command sequencing, read-before-write priority with a starvation bound, and outstanding-read flow control. Instantiated in the top level between the camera/VGA pipelines and the NIOS system.

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_rd_tracker.sv | 50 +++++
 rtl/sdram_port_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: command slot
// states, fixed Avalon sideband values and word-to-byte address mapping.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_RD    = 2'd1,
    SLOT_WR    = 2'd2
  } slot_e;

  localparam logic [1:0] BYTE_EN_ALL = 2'b11;
  localparam logic       BURST_ONE   = 1'b1;

  // 16-bit words map to even byte addresses; wraps modulo 2^32.
  function automatic logic [31:0] word_to_byte(input logic [31:0] base,
                                               input logic [31:0] word);
    return base + {word[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/sdram_rd_tracker.sv
// Outstanding-read accounting and registered read-data return path.
// Flags pending_full so the arbiter stops granting reads at the limit.
module sdram_rd_tracker #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_issue,
  input  logic        slot_rd,
  input  logic        rdv,
  input  logic [15:0] rdata,
  output logic        pending_full,
  output logic [15:0] rd_data,
  output logic        rd_valid
);

  logic [3:0] pending_q;
  logic [4:0] eff_count;

  // A read still waiting in the command slot will become outstanding, so it counts too.
  assign eff_count    = {1'b0, pending_q} + 5'(slot_rd);
  assign pending_full = eff_count >= 5'(MAX_PENDING);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      unique case ({rd_issue, rdv})
        2'b10:   pending_q <= pending_q + 4'd1;
        2'b01:   if (pending_q != '0) pending_q <= pending_q - 4'd1;
        default: pending_q <= pending_q;
      endcase
    end
  end

  // NOTE: rd_data is a plain datapath register but is still reset so the
  // output is defined before the first return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rdv;
      if (rdv) rd_data <= rdata;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM master between the capture writer and the
// scan-out reader: read-first grant with a starvation bound, one command slot.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_PENDING = 4,
  parameter int          RD_STREAK   = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  output logic              avm_burstcount,
  output logic              avm_debugaccess,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int STREAK_W = $clog2(RD_STREAK + 2);

  slot_e               slot_q, slot_d;
  logic [31:0]         addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic accept, can_load, rd_elig, rd_wins, grant_rd, grant_wr;
  logic pending_full;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    accept   = (slot_q != SLOT_EMPTY) && !avm_waitrequest;
    // Reset gates the grants so no ack escapes while the slot is held empty.
    can_load = reset_reset_n && ((slot_q == SLOT_EMPTY) || accept);
    rd_elig  = rd_req && !pending_full;
    rd_wins  = rd_elig && (!wr_req || (streak_q != STREAK_W'(RD_STREAK)));
    grant_rd = can_load && rd_wins;
    grant_wr = can_load && wr_req && !rd_wins;

    slot_d   = slot_q;
    addr_d   = addr_q;
    data_d   = data_q;
    streak_d = streak_q;

    if (grant_rd) begin
      slot_d = SLOT_RD;
      addr_d = word_to_byte(BASE_ADDR, 32'(rd_addr));
    end else if (grant_wr) begin
      slot_d = SLOT_WR;
      addr_d = word_to_byte(BASE_ADDR, 32'(wr_addr));
      data_d = wr_data;
    end else if (accept) begin
      slot_d = SLOT_EMPTY;
    end

    // Streak only measures how long a waiting write has been passed over.
    if (grant_wr || !wr_req) streak_d = '0;
    else if (grant_rd)       streak_d = streak_q + STREAK_W'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      slot_q   <= SLOT_EMPTY;
      addr_q   <= '0;
      data_q   <= '0;
      streak_q <= '0;
    end else begin
      slot_q   <= slot_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      streak_q <= streak_d;
    end
  end

  assign wr_ack          = grant_wr;
  assign rd_ack          = grant_rd;
  assign avm_read        = (slot_q == SLOT_RD);
  assign avm_write       = (slot_q == SLOT_WR);
  assign avm_address     = addr_q;
  assign avm_writedata   = data_q;
  assign avm_byteenable  = BYTE_EN_ALL;
  assign avm_burstcount  = BURST_ONE;
  assign avm_debugaccess = 1'b0;

  sdram_rd_tracker #(
    .MAX_PENDING(MAX_PENDING)
  ) u_rd_tracker (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .rd_issue    (accept && (slot_q == SLOT_RD)),
    .slot_rd     (slot_q == SLOT_RD),
    .rdv         (avm_readdatavalid),
    .rdata       (avm_readdata),
    .pending_full(pending_full),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

endmodule
